// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path: FSM states,
// cycle-count derivations and the common host-to-device command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE, INHIBIT, RTS, DATA, PARITY, STOP, ACK, WAIT_IDLE
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_RESEND  = 8'hFE;

    // 64-bit intermediate: 120 us * 25 MHz already overflows a 32-bit int.
    function automatic int inhibit_cycles(input longint clk_hz, input longint us);
        return int'((clk_hz * us) / 64'd1000000);
    endfunction

    function automatic int timeout_cycles(input longint clk_hz, input longint ms);
        return int'((clk_hz * ms) / 64'd1000);
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Core-side byte handshake and transfer status of the PS/2 host transmitter.
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       err_timeout;

    modport master (output tx_valid, tx_data,
                    input  tx_ready, busy, done, ack_ok, err_timeout);
    modport slave  (input  tx_valid, tx_data,
                    output tx_ready, busy, done, ack_ok, err_timeout);
endinterface

// File: rtl/ps2_line_sync.sv
// PS/2 pin conditioning: 2-flop synchronizers on clock and data, a run-length
// filter on the clock, and a one-cycle pulse on each filtered falling edge.
module ps2_line_sync
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clk_raw_i,
    input  logic dat_raw_i,
    output logic clk_o,
    output logic dat_o,
    output logic fall_o
);
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] run_q, run_d;
    logic          fall_q;

    // The filtered level only follows after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        run_d  = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (run_q == CW'(FILTER_LEN - 1)) filt_d = clk_sync_q[1];
            else                              run_d  = run_q + 1'b1;
        end
    end

    // Idle bus is high, so sync/filter start at 1 to avoid a spurious edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            run_q      <= '0;
            fall_q     <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], clk_raw_i};
            dat_sync_q <= {dat_sync_q[0], dat_raw_i};
            filt_q     <= filt_d;
            run_q      <= run_d;
            fall_q     <= filt_q & ~filt_d;
        end
    end

    assign clk_o  = filt_q;
    assign dat_o  = dat_sync_q[1];
    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (inhibit, RTS, device-clocked frame, ACK).
// Define PS2_HOST_TX_TIMEOUT_EN to add the no-clock / frame-span watchdog.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 25_000_000,
    parameter int INHIBIT_US = 120,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_MS = 15
) (
    input  logic         clk,
    input  logic         reset_n,
    ps2_host_tx_if.slave bus,
    input  logic         ps2_clk_i,
    input  logic         ps2_dat_i,
    output logic         ps2_clk_oe,
    output logic         ps2_dat_oe
);
    localparam int INH_CYC = inhibit_cycles(CLK_HZ, INHIBIT_US);
    localparam int TW      = (INH_CYC > 1) ? $clog2(INH_CYC) : 1;

    logic clk_s, dat_s, fall;

    ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk_raw_i (ps2_clk_i),
        .dat_raw_i (ps2_dat_i),
        .clk_o     (clk_s),
        .dat_o     (dat_s),
        .fall_o    (fall)
    );

    ps2_state_e    state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          par_q, par_d;
    logic          ack_int_q, ack_int_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic          done_q, done_d;
    logic          ack_ok_q, ack_ok_d;

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int TO_CYC   = timeout_cycles(CLK_HZ, TIMEOUT_MS);
    localparam int SPAN_CYC = timeout_cycles(CLK_HZ, 2);
    localparam int WW       = $clog2(((TO_CYC > SPAN_CYC) ? TO_CYC : SPAN_CYC) + 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          first_q, first_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        tmr_d     = tmr_q;
        par_d     = par_q;
        ack_int_d = ack_int_q;
        dat_oe_d  = dat_oe_q;
        done_d    = 1'b0;
        ack_ok_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                dat_oe_d = 1'b0;
                if (bus.tx_valid) begin
                    shift_d = bus.tx_data;
                    par_d   = ~^bus.tx_data;
                    cnt_d   = '0;
                    tmr_d   = '0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (tmr_q == TW'(INH_CYC - 1)) begin
                    state_d  = RTS;
                    dat_oe_d = 1'b1;    // start bit, pulled while clock is still held
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            RTS: begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: if (fall) begin
                dat_oe_d = ~shift_q[0];
                shift_d  = {1'b0, shift_q[7:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == 4'd7) state_d = PARITY;
            end
            PARITY: if (fall) begin
                dat_oe_d = ~par_q;
                state_d  = STOP;
            end
            STOP: if (fall) begin
                dat_oe_d = 1'b0;
                state_d  = ACK;
            end
            ACK: if (fall) begin
                ack_int_d = ~dat_s;
                state_d   = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                dat_oe_d = 1'b0;
                if (clk_s && dat_s) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    ack_ok_d = ack_int_q;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
        // Counter only runs between RTS exit and the ACK edge, so every accept
        // starts it from zero. It measures the first-clock wait, then restarts
        // at the first fall to bound the remainder of the frame.
        wd_d    = '0;
        first_d = 1'b0;
        err_d   = 1'b0;
        if (state_q inside {DATA, PARITY, STOP, ACK}) begin
            wd_d    = wd_q + 1'b1;
            first_d = first_q;
            if (fall && !first_q) begin
                first_d = 1'b1;
                wd_d    = '0;
            end
            if ((!first_q && wd_q == WW'(TO_CYC - 1)) ||
                ( first_q && wd_q == WW'(SPAN_CYC - 1))) begin
                state_d  = IDLE;
                dat_oe_d = 1'b0;
                done_d   = 1'b1;
                ack_ok_d = 1'b0;
                err_d    = 1'b1;
                first_d  = 1'b0;
                wd_d     = '0;
            end
        end
`endif

        clk_oe_d = (state_d == INHIBIT) || (state_d == RTS);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            tmr_q     <= '0;
            par_q     <= 1'b0;
            ack_int_q <= 1'b0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            done_q    <= 1'b0;
            ack_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            par_q     <= par_d;
            ack_int_q <= ack_int_d;
            clk_oe_q  <= clk_oe_d;
            dat_oe_q  <= dat_oe_d;
            done_q    <= done_d;
            ack_ok_q  <= ack_ok_d;
        end
    end

`ifdef PS2_HOST_TX_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q    <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            first_q <= first_d;
            err_q   <= err_d;
        end
    end
    assign bus.err_timeout = err_q;
`else
    assign bus.err_timeout = 1'b0;
`endif

    assign bus.tx_ready = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.ack_ok   = ack_ok_q;
    assign ps2_clk_oe   = clk_oe_q;
    assign ps2_dat_oe   = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a device model that clocks frames
// and ACKs/NACKs; expected frames and done status flow through scoreboard queues.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_pkg::*;

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int CLK_HZ  = 2_000_000;
    localparam int INH_EXP = 240;       // 120 us at 2 MHz
    localparam int TO_EXP  = 30_000;    // 15 ms at 2 MHz
`else
    localparam int CLK_HZ  = 25_000_000;
    localparam int INH_EXP = 3000;      // 120 us at 25 MHz
`endif
    localparam int HALF_SLOW = CLK_HZ / 25_000;   // 40 us half period = 12.5 kHz
    localparam int HALF_FAST = 50;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ps2_clk_oe, ps2_dat_oe;
    logic dev_clk_low = 1'b0, dev_dat_low = 1'b0;
    logic clk_line, dat_line;

    assign clk_line = ~(ps2_clk_oe | dev_clk_low);
    assign dat_line = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx_if bus ();

    ps2_host_tx #(.CLK_HZ(CLK_HZ)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .ps2_clk_i  (clk_line),
        .ps2_dat_i  (dat_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #20 clk = ~clk;

    int n_tests = 0, n_fail = 0, n_done = 0, viol = 0;
    int clk_run = 0, ovl_run = 0, last_run = 0, last_ovl = 0;
    logic [9:0] exp_frame_q[$];   // {stop, parity, d7..d0} as seen at rising edges
    logic [1:0] exp_done_q[$];    // {ack_ok, err_timeout}

    int dev_half = HALF_SLOW, dev_rise = 0;
    bit dev_ack = 1'b1, dev_glitch = 1'b0, dev_silent = 1'b0;
    bit dev_abort = 1'b0, dev_active = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Device model: waits for RTS (clock released, data low), then clocks 11 bits.
    initial begin : device
        logic [9:0] bits;
        forever begin
            @(posedge clk);
            if (reset_n && bus.busy && !ps2_clk_oe && ps2_dat_oe && !dev_active) begin
                dev_active = 1'b1;
                bits = '0;
                if (dev_silent) begin
                    while (bus.busy && !dev_abort) @(posedge clk);
                end else begin
                    repeat (dev_half) @(posedge clk);
                    for (int i = 0; i < 11 && !dev_abort; i++) begin
                        dev_clk_low = 1'b1;
                        repeat (dev_half) @(posedge clk);
                        if (i < 10) bits[i] = dat_line;
                        dev_clk_low = 1'b0;
                        dev_rise++;
                        if (i == 9)  dev_dat_low = dev_ack;
                        if (i == 10) dev_dat_low = 1'b0;
                        if (dev_glitch && i >= 1 && i <= 7) begin
                            repeat (dev_half / 3) @(posedge clk);
                            dev_clk_low = 1'b1;
                            repeat (3) @(posedge clk);
                            dev_clk_low = 1'b0;
                            repeat (dev_half - dev_half / 3 - 3) @(posedge clk);
                        end else begin
                            repeat (dev_half) @(posedge clk);
                        end
                    end
                    dev_clk_low = 1'b0;
                    dev_dat_low = 1'b0;
                    if (!dev_abort) begin
                        if (exp_frame_q.size() == 0) begin
                            n_tests++; n_fail++;
                            $display("FAIL frame: unexpected frame %b", bits);
                        end else begin
                            chk("frame", {22'd0, bits}, {22'd0, exp_frame_q.pop_front()});
                        end
                    end
                end
                dev_active = 1'b0;
            end
        end
    end

    // Monitor: done status against the scoreboard, line invariant, inhibit length.
    always @(negedge clk) begin : monitor
        logic [1:0] e;
        if (bus.done) begin
            n_done++;
            if (exp_done_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL done: unexpected done, ack_ok %0b err %0b", bus.ack_ok, bus.err_timeout);
            end else begin
                e = exp_done_q.pop_front();
                chk("ack_ok", {31'd0, bus.ack_ok}, {31'd0, e[1]});
                chk("err_timeout", {31'd0, bus.err_timeout}, {31'd0, e[0]});
            end
        end
        if ((ps2_clk_oe || ps2_dat_oe) && !bus.busy) viol++;
        if (ps2_clk_oe) begin
            clk_run++;
            if (ps2_dat_oe) ovl_run++;
        end else if (clk_run != 0) begin
            last_run = clk_run;
            last_ovl = ovl_run;
            clk_run  = 0;
            ovl_run  = 0;
        end
    end

    task automatic issue(input logic [7:0] d, input string tag);
        int i;
        for (i = 0; i < 1000 && !bus.tx_ready; i++) @(negedge clk);
        chk({tag, "_ready_wait"}, {31'd0, bus.tx_ready}, 32'd1);
        @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        chk({tag, "_ready_drop"}, {31'd0, bus.tx_ready}, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input logic [9:0] fr, input bit ack,
                        input logic [1:0] exp_d, input string tag);
        exp_frame_q.push_back(fr);
        exp_done_q.push_back(exp_d);
        dev_ack = ack;
        issue(d, tag);
    endtask

    task automatic wait_done(input int target, input int bound, input string tag, output int el);
        el = 0;
        while (el < bound && n_done < target) begin
            @(negedge clk);
            el++;
        end
        chk({tag, "_done_seen"}, {31'd0, n_done >= target}, 32'd1);
    endtask

    task automatic wait_dev_idle(input string tag);
        for (int i = 0; i < 5000 && dev_active; i++) @(negedge clk);
        chk({tag, "_dev_idle"}, {31'd0, dev_active}, 32'd0);
    endtask

    initial begin : global_guard
        #20ms;
        $display("FAIL global_timeout: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int el;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_ack_ok", {31'd0, bus.ack_ok}, 32'd0);
        chk("rst_err", {31'd0, bus.err_timeout}, 32'd0);
        chk("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        chk("rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0xED at 12.5 kHz: bits 1,0,1,1,0,1,1,1, parity 1, stop 1
        dev_half = HALF_SLOW;
        send(PS2_CMD_SET_LED, 10'b1_1_11101101, 1'b1, 2'b10, "led");
        wait_done(1, 40000, "led", el);
        chk("inhibit_len", last_run, INH_EXP + 1);
        chk("rts_overlap", last_ovl, 1);
        chk("led_ready_back", {31'd0, bus.tx_ready}, 32'd1);
        wait_dev_idle("led");

        // 0x01: parity 0; a tx_valid offered mid-transfer must be ignored
        dev_half = HALF_FAST;
        send(8'h01, 10'b1_0_00000001, 1'b1, 2'b10, "b01");
        repeat (20) @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h55;
        repeat (3) @(negedge clk);
        chk("busy_not_ready", {31'd0, bus.tx_ready}, 32'd0);
        bus.tx_valid = 1'b0;
        wait_done(2, 8000, "b01", el);
        wait_dev_idle("b01");

        // 0xFF: parity 1
        send(PS2_CMD_RESET, 10'b1_1_11111111, 1'b1, 2'b10, "bff");
        wait_done(3, 8000, "bff", el);
        wait_dev_idle("bff");

        // 0xF4 NACKed, then the next byte is still accepted
        send(PS2_CMD_ENABLE, 10'b1_0_11110100, 1'b0, 2'b00, "nack");
        wait_done(4, 8000, "nack", el);
        wait_dev_idle("nack");
        send(PS2_CMD_RESEND, 10'b1_0_11111110, 1'b1, 2'b10, "after_nack");
        wait_done(5, 8000, "after_nack", el);
        wait_dev_idle("after_nack");

        // 3-cycle clock glitches in the high phases of the data bits
        dev_glitch = 1'b1;
        send(PS2_CMD_SET_LED, 10'b1_1_11101101, 1'b1, 2'b10, "glitch");
        wait_done(6, 8000, "glitch", el);
        wait_dev_idle("glitch");
        dev_glitch = 1'b0;

        // Reset after the 4th data bit: lines released at once, no done
        dev_rise = 0;
        issue(8'h00, "abort");
        for (int i = 0; i < 8000 && dev_rise < 4; i++) @(negedge clk);
        chk("abort_reached_bit4", {31'd0, dev_rise >= 4}, 32'd1);
        chk("abort_pre_dat_oe", {31'd0, ps2_dat_oe}, 32'd1);
        #5;
        reset_n   = 1'b0;
        dev_abort = 1'b1;
        #1;
        chk("abort_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        chk("abort_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_dev_idle("abort");
        dev_abort = 1'b0;
        repeat (200) @(negedge clk);
        chk("abort_ready", {31'd0, bus.tx_ready}, 32'd1);
        chk("abort_no_done", n_done, 6);

        // Device never clocks after RTS
        dev_silent = 1'b1;
`ifdef PS2_HOST_TX_TIMEOUT_EN
        exp_done_q.push_back(2'b01);
        issue(8'h00, "silent");
        wait_done(7, INH_EXP + TO_EXP + 500, "silent", el);
        chk("silent_not_early", {31'd0, el >= TO_EXP}, 32'd1);
        @(negedge clk);
        chk("silent_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        chk("silent_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
        chk("silent_ready", {31'd0, bus.tx_ready}, 32'd1);
`else
        issue(8'h00, "silent");
        repeat (INH_EXP + 8000) @(negedge clk);
        chk("silent_still_busy", {31'd0, bus.busy}, 32'd1);
        chk("silent_no_done", n_done, 6);
        chk("silent_clk_released", {31'd0, ps2_clk_oe}, 32'd0);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("silent_recovered", {31'd0, bus.tx_ready}, 32'd1);
`endif
        wait_dev_idle("silent");
        dev_silent = 1'b0;

        chk("line_invariant", viol, 0);
        chk("frames_consumed", exp_frame_q.size(), 0);
        chk("dones_consumed", exp_done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
